// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall / flush / redirect controller for the 5-stage MIPS pipeline.
//   Resolves, in priority order:
//   - overflow exceptions reported from MEM/WB
//   - taken jumps/branches resolved in EX
//   - load-use and mult/div (HI/LO) occupancy hazards seen from ID
//   It also holds the exception PC.
//
// Ports
//   clk, rst                     pipeline clock, synchronous active-high reset
//   id_rs, id_rt                 source register fields of the ID instruction
//   id_uses_rs, id_uses_rt       ID instruction actually reads rs / rt
//   id_mdu_op                    ID instruction touches the mult/div unit or HI/LO
//   ex_memread, ex_rw            EX instruction is a load, and its destination
//   ex_mdu_start                 mult/div issues from EX this cycle
//   ex_jump_taken, ex_jtarget    taken branch/jump resolved in EX, and its target
//   wr_overflow, wr_pcadd4       overflow flag and pc+4 of the MEM/WB instruction
//   pc_stall, ifid_stall         hold the PC / IF-ID register
//   ifid_flush .. memwr_flush    clear the corresponding pipeline register
//   wb_kill                      suppress the register write in WB this cycle
//   pc_redirect, pc_target       load pc_target into the PC (target is 0 otherwise)
//   epc                          address of the last overflowing instruction
//   mdu_busy                     mult/div countdown is nonzero
module pipe_hazard_ctrl #(
  parameter int          MDU_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR = 32'h00004180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_mdu_op,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rw,
  input  logic        ex_mdu_start,
  input  logic        ex_jump_taken,
  input  logic [31:0] ex_jtarget,
  input  logic        wr_overflow,
  input  logic [31:0] wr_pcadd4,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwr_flush,
  output logic        wb_kill,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic [31:0] epc,
  output logic        mdu_busy
);

  typedef enum logic {RUN, EXC_DRAIN} state_t;

  localparam logic [5:0] MDU_LOAD = 6'(MDU_CYCLES);

  state_t     state;
  logic [5:0] mdu_cnt;

  logic busy;
  logic in_run;
  logic exc;
  logic jmp;
  logic lu_hz;
  logic mdu_hz;
  logic stall;

  // The overflowing instruction is the one before its own pc+4; wraps mod 2^32.
  function automatic logic [31:0] ret_addr(input logic [31:0] pcadd4);
    return pcadd4 - 32'd4;
  endfunction

  always_comb begin
    busy   = (mdu_cnt != 6'd0);
    in_run = (state == RUN) && !rst;
    // $0 is hardwired to zero, so a load into it never creates a dependence.
    lu_hz  = ex_memread && (ex_rw != 5'd0) &&
             ((id_uses_rs && (id_rs == ex_rw)) || (id_uses_rt && (id_rt == ex_rw)));
    mdu_hz = id_mdu_op && busy;
    exc    = in_run && wr_overflow;
    jmp    = in_run && !wr_overflow && ex_jump_taken;
    stall  = in_run && !wr_overflow && !ex_jump_taken && (lu_hz || mdu_hz);
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwr_flush = 1'b0;
    wb_kill     = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 32'd0;
    mdu_busy    = busy && !rst;
    if (!rst) begin
      if (state == EXC_DRAIN) begin
        // The instruction fetched during the exception cycle came from the old
        // stream; only IF/ID still holds something to discard.
        ifid_flush = 1'b1;
      end else if (exc) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwr_flush = 1'b1;
        wb_kill     = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = EXC_VECTOR;
      end else if (jmp) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = ex_jtarget;
      end else if (stall) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      mdu_cnt <= 6'd0;
      epc     <= 32'd0;
    end else begin
      case (state)
        RUN:       if (exc) state <= EXC_DRAIN;
        EXC_DRAIN: state <= RUN;
        default:   state <= RUN;
      endcase

      if (exc) epc <= ret_addr(wr_pcadd4);

      // Exception cancels any younger mult/div; otherwise a new issue
      // (re)loads the count, and it keeps draining through stalls and flushes.
      if (exc)               mdu_cnt <= 6'd0;
      else if (ex_mdu_start) mdu_cnt <= MDU_LOAD;
      else if (busy)         mdu_cnt <= mdu_cnt - 6'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_mdu_op;
    logic        ex_memread;
    logic [4:0]  ex_rw;
    logic        ex_mdu_start;
    logic        ex_jump_taken;
    logic [31:0] ex_jtarget;
    logic        wr_overflow;
    logic [31:0] wr_pcadd4;
  } in_t;

  typedef struct packed {
    logic        pc_stall;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        memwr_flush;
    logic        wb_kill;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [31:0] epc;
    logic        mdu_busy;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rw;
  logic        id_uses_rs, id_uses_rt, id_mdu_op, ex_memread;
  logic        ex_mdu_start, ex_jump_taken, wr_overflow;
  logic [31:0] ex_jtarget, wr_pcadd4;
  logic        pc_stall, ifid_stall, ifid_flush, idex_flush;
  logic        exmem_flush, memwr_flush, wb_kill, pc_redirect, mdu_busy;
  logic [31:0] pc_target, epc;

  int errors = 0;
  int checks = 0;
  out_t sb_q[$];
  string name_q[$];

  pipe_hazard_ctrl #(.MDU_CYCLES(32), .EXC_VECTOR(32'h00004180)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdu_op(id_mdu_op), .ex_memread(ex_memread), .ex_rw(ex_rw),
    .ex_mdu_start(ex_mdu_start), .ex_jump_taken(ex_jump_taken), .ex_jtarget(ex_jtarget),
    .wr_overflow(wr_overflow), .wr_pcadd4(wr_pcadd4),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwr_flush(memwr_flush),
    .wb_kill(wb_kill), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .epc(epc), .mdu_busy(mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic in_t i_idle();
    in_t i;
    i = '0;
    return i;
  endfunction

  function automatic out_t o_none(input logic [31:0] e, input logic b);
    out_t o;
    o = '0;
    o.epc = e;
    o.mdu_busy = b;
    return o;
  endfunction

  function automatic out_t o_stall(input logic [31:0] e, input logic b);
    out_t o;
    o = o_none(e, b);
    o.pc_stall = 1'b1;
    o.ifid_stall = 1'b1;
    o.idex_flush = 1'b1;
    return o;
  endfunction

  function automatic out_t o_jump(input logic [31:0] t, input logic [31:0] e, input logic b);
    out_t o;
    o = o_none(e, b);
    o.ifid_flush = 1'b1;
    o.idex_flush = 1'b1;
    o.pc_redirect = 1'b1;
    o.pc_target = t;
    return o;
  endfunction

  function automatic out_t o_exc(input logic [31:0] e, input logic b);
    out_t o;
    o = o_none(e, b);
    o.ifid_flush = 1'b1;
    o.idex_flush = 1'b1;
    o.exmem_flush = 1'b1;
    o.memwr_flush = 1'b1;
    o.wb_kill = 1'b1;
    o.pc_redirect = 1'b1;
    o.pc_target = 32'h00004180;
    return o;
  endfunction

  function automatic out_t o_drain(input logic [31:0] e, input logic b);
    out_t o;
    o = o_none(e, b);
    o.ifid_flush = 1'b1;
    return o;
  endfunction

  // Drive one cycle's inputs just after the rising edge, queue the expected
  // outputs, compare on the falling edge, then advance to the next cycle.
  task automatic step(input in_t i, input out_t e, input string nm);
    out_t act;
    out_t exp_o;
    string n;
    rst           = i.rst;
    id_rs         = i.id_rs;
    id_rt         = i.id_rt;
    id_uses_rs    = i.id_uses_rs;
    id_uses_rt    = i.id_uses_rt;
    id_mdu_op     = i.id_mdu_op;
    ex_memread    = i.ex_memread;
    ex_rw         = i.ex_rw;
    ex_mdu_start  = i.ex_mdu_start;
    ex_jump_taken = i.ex_jump_taken;
    ex_jtarget    = i.ex_jtarget;
    wr_overflow   = i.wr_overflow;
    wr_pcadd4     = i.wr_pcadd4;
    sb_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    act = {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush, memwr_flush,
           wb_kill, pc_redirect, pc_target, epc, mdu_busy};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, actual=%h", nm, act);
    end else begin
      exp_o = sb_q.pop_front();
      n = name_q.pop_front();
      if (act !== exp_o) begin
        errors++;
        $display("FAIL %s: actual=%h expected=%h", n, act, exp_o);
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[8];
  in_t  v;

  initial begin
    // Reset held with an overflow pending: everything must stay quiet.
    v = i_idle();
    v.rst = 1'b1;
    v.wr_overflow = 1'b1;
    v.wr_pcadd4 = 32'h0000301C;
    rst = 1'b1;
    wr_overflow = 1'b1;
    {id_rs, id_rt, ex_rw} = '0;
    {id_uses_rs, id_uses_rt, id_mdu_op, ex_memread, ex_mdu_start, ex_jump_taken} = '0;
    ex_jtarget = '0;
    wr_pcadd4 = '0;
    @(posedge clk);
    #1;
    step(v, o_none(32'd0, 1'b0), "reset_c1");
    step(v, o_none(32'd0, 1'b0), "reset_c2");
    step(i_idle(), o_none(32'd0, 1'b0), "after_reset");

    // Single-cycle combinational cases from RUN with the MDU idle and epc=0.
    for (int k = 0; k < 8; k++) tbl[k].i = i_idle();
    tbl[0].e = o_none(32'd0, 1'b0);
    tbl[1].i.ex_memread = 1'b1; tbl[1].i.ex_rw = 5'd8; tbl[1].i.id_rs = 5'd8;
    tbl[1].i.id_uses_rs = 1'b1;  tbl[1].e = o_stall(32'd0, 1'b0);
    tbl[2].i.ex_memread = 1'b1; tbl[2].i.ex_rw = 5'd0; tbl[2].i.id_rs = 5'd0;
    tbl[2].i.id_uses_rs = 1'b1;  tbl[2].e = o_none(32'd0, 1'b0);
    tbl[3].i.ex_memread = 1'b1; tbl[3].i.ex_rw = 5'd5; tbl[3].i.id_rt = 5'd5;
    tbl[3].i.id_uses_rt = 1'b1;  tbl[3].e = o_stall(32'd0, 1'b0);
    tbl[4].i.ex_memread = 1'b1; tbl[4].i.ex_rw = 5'd8; tbl[4].i.id_rs = 5'd8;
    tbl[4].i.id_uses_rs = 1'b0;  tbl[4].e = o_none(32'd0, 1'b0);
    tbl[5].i.ex_memread = 1'b0; tbl[5].i.ex_rw = 5'd8; tbl[5].i.id_rs = 5'd8;
    tbl[5].i.id_uses_rs = 1'b1;  tbl[5].e = o_none(32'd0, 1'b0);
    tbl[6].i.ex_memread = 1'b1; tbl[6].i.ex_rw = 5'd8; tbl[6].i.id_rs = 5'd8;
    tbl[6].i.id_uses_rs = 1'b1;  tbl[6].i.ex_jump_taken = 1'b1;
    tbl[6].i.ex_jtarget = 32'h00003040; tbl[6].e = o_jump(32'h00003040, 32'd0, 1'b0);
    tbl[7].i.id_mdu_op = 1'b1;   tbl[7].e = o_none(32'd0, 1'b0);
    for (int k = 0; k < 8; k++) step(tbl[k].i, tbl[k].e, $sformatf("vec%0d", k));

    // MDU occupancy: issue at cycle 0, stall cycles 1-32, release at 33.
    v = i_idle();
    v.ex_mdu_start = 1'b1;
    step(v, o_none(32'd0, 1'b0), "mdu_issue");
    v = i_idle();
    v.id_mdu_op = 1'b1;
    for (int c = 1; c <= 32; c++) step(v, o_stall(32'd0, 1'b1), $sformatf("mdu_stall_c%0d", c));
    step(v, o_none(32'd0, 1'b0), "mdu_release");

    // Jump in the same cycle as an issue: redirect happens and the count loads.
    v = i_idle();
    v.ex_jump_taken = 1'b1;
    v.ex_jtarget = 32'h00001234;
    v.ex_mdu_start = 1'b1;
    step(v, o_jump(32'h00001234, 32'd0, 1'b0), "jump_with_issue");
    // Count now 32; idle until it reads 10 (22 cycles of 32..11).
    for (int c = 0; c < 22; c++) step(i_idle(), o_none(32'd0, 1'b1), $sformatf("mdu_count_c%0d", c));

    // Exception beats a jump; epc and count update on the edge, drain next.
    v = i_idle();
    v.wr_overflow = 1'b1;
    v.wr_pcadd4 = 32'h0000301C;
    v.ex_jump_taken = 1'b1;
    v.ex_jtarget = 32'h00003040;
    step(v, o_exc(32'd0, 1'b1), "exc_cycle");
    v.wr_pcadd4 = 32'h00005000;
    step(v, o_drain(32'h00003018, 1'b0), "exc_drain");
    step(i_idle(), o_none(32'h00003018, 1'b0), "after_drain");

    // epc wraps modulo 2^32.
    v = i_idle();
    v.wr_overflow = 1'b1;
    v.wr_pcadd4 = 32'h00000002;
    step(v, o_exc(32'h00003018, 1'b0), "exc_wrap");
    step(i_idle(), o_drain(32'hFFFFFFFE, 1'b0), "wrap_drain");
    step(i_idle(), o_none(32'hFFFFFFFE, 1'b0), "wrap_run");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/redirect controller for the 5-stage MIPS pipeline.
- Drives the stall inputs of the PC and IF/ID registers, and the Flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Handles load-use stalls, multicycle mult/div occupancy, taken jumps/branches resolved in EX, and overflow exceptions detected at MEM/WB.
- Holds the exception PC (EPC).

Parameters:
MDU_CYCLES, 32, cycles a mult/div occupies HI/LO after issue from EX (legal range 2..63).
EXC_VECTOR, 32'h00004180, PC loaded on overflow exception.

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_mdu_op  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
ex_memread  in  1  EX instruction is a load
ex_rw  in  5  destination register of the EX instruction
ex_mdu_start  in  1  mult/div in EX this cycle
ex_jump_taken  in  1  EX resolved a taken branch/jump
ex_jtarget  in  32  target of that branch/jump
wr_overflow  in  1  Overflow flag from MEM/WB
wr_pcadd4  in  32  pcadd4 from MEM/WB
pc_stall  out  1  hold the PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  clear IF/ID
idex_flush  out  1  clear ID/EX (insert bubble)
exmem_flush  out  1  clear EX/MEM
memwr_flush  out  1  clear MEM/WB
wb_kill  out  1  suppress register write in WB this cycle
pc_redirect  out  1  load pc_target into the PC
pc_target  out  32  redirect address
epc  out  32  address of the last overflowing instruction
mdu_busy  out  1  MDU countdown nonzero

Behaviour:
- Registered state:
  - FSM state: RUN or EXC_DRAIN.
  - mdu_cnt: 6 bits.
  - epc: 32 bits.
- Reset (rst=1 at posedge): state=RUN, mdu_cnt=0, epc=0. While rst=1, every combinational output is driven 0 and pc_target is 0.
- mdu_busy = (mdu_cnt != 0).
- Conditions, evaluated each cycle in RUN:
  - exc = wr_overflow.
  - jmp = ex_jump_taken.
  - mdu_hz = id_mdu_op & mdu_busy.
  - lu_hz = ex_memread & (ex_rw != 0) & ((id_uses_rs & id_rs == ex_rw) | (id_uses_rt & id_rt == ex_rw)).
- Priority: exc > jmp > (mdu_hz | lu_hz). A lower-priority condition produces no effect when a higher one is active.
- exc (RUN):
  - Outputs: ifid_flush, idex_flush, exmem_flush, memwr_flush, wb_kill, pc_redirect = 1; pc_target = EXC_VECTOR; stalls = 0.
  - Next-edge updates: epc <= wr_pcadd4 - 4, mdu_cnt <= 0 (younger mult/div cancelled), state <= EXC_DRAIN.
- EXC_DRAIN (exactly 1 cycle):
  - Outputs: ifid_flush = 1, all other outputs 0; wr_overflow is ignored.
  - Next state: RUN.
- jmp (RUN, no exc):
  - Outputs: ifid_flush = 1, idex_flush = 1, pc_redirect = 1, pc_target = ex_jtarget; stalls = 0.
- stall (RUN, neither exc nor jmp, mdu_hz or lu_hz):
  - Outputs: pc_stall = 1, ifid_stall = 1, idex_flush = 1; everything else 0.
  - Load-use stall lasts exactly 1 cycle.
  - MDU stall persists until the cycle in which mdu_cnt == 0.
- mdu_cnt update, in priority order:
  - exc: mdu_cnt <= 0.
  - ex_mdu_start: mdu_cnt <= MDU_CYCLES.
  - mdu_cnt != 0: decrement by 1 per cycle.
  - Decrement continues during stalls, jumps and EXC_DRAIN.
  - ex_mdu_start while busy restarts the count; this cannot happen normally because of mdu_hz.
- ex_mdu_start together with jmp: the mult/div is valid and the count loads.
- Register $0 never causes a load-use stall.
- pc_target = 0 whenever pc_redirect = 0.
- wr_pcadd4 - 4 wraps modulo 2^32.

Test Plan:
- Reset: hold rst=1 for 2 cycles with wr_overflow=1 -> all outputs 0, epc=0; after release, state RUN, mdu_busy=0.
- Load-use: ex_memread=1, ex_rw=8, id_rs=8, id_uses_rs=1 for one cycle -> pc_stall=ifid_stall=idex_flush=1 that cycle only. The same stimulus with ex_rw=0 produces no stall.
- MDU: ex_mdu_start pulse at cycle 0 with MDU_CYCLES=32, then id_mdu_op=1 held -> mdu_busy cycles 1-32, stall asserted cycles 1-32, released at cycle 33.
- Jump versus stall: ex_jump_taken=1, ex_jtarget=32'h00003040, lu_hz conditions true -> pc_redirect=1, pc_target=32'h00003040, ifid_flush=idex_flush=1, pc_stall=0.
- Exception: wr_overflow=1, wr_pcadd4=32'h0000301C, ex_jump_taken=1, mdu_cnt=10 ->
  - Same cycle: all four flushes, wb_kill=1, pc_target=32'h00004180.
  - Next edge: epc=32'h00003018, mdu_cnt=0.
  - Next cycle: ifid_flush only.
- Drain ignore: wr_overflow held high for 2 cycles -> second cycle (EXC_DRAIN) shows no pc_redirect and epc is unchanged.
